// File: rtl/window_fetch_ctrl.sv
// window_fetch_ctrl: walks a KxK stride-1 window over a WxH row-major image
// in the feature-map buffer. It issues one read per cycle and re-times the
// 1-cycle buffer latency through a 2-entry FIFO. The FIFO feeds a
// valid/ready pixel stream that carries window-last and frame-last tags.
module window_fetch_ctrl #(
  parameter int ADDR_W = 13,
  parameter int DATA_W = 16,
  parameter int K      = 5,
  parameter int DIM_W  = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic [ADDR_W-1:0] cfg_base,
  input  logic [DIM_W-1:0]  cfg_w,
  input  logic [DIM_W-1:0]  cfg_h,
  output logic              busy,
  output logic              done,
  output logic              err,
  output logic              buf_rd_en,
  output logic [ADDR_W-1:0] buf_rd_addr,
  input  logic [DATA_W-1:0] buf_rd_data,
  output logic [DATA_W-1:0] pix_data,
  output logic              pix_valid,
  input  logic              pix_ready,
  output logic              pix_win_last,
  output logic              pix_frame_last
);

  localparam int KC_W = (K > 1) ? $clog2(K) : 1;
  localparam logic [KC_W-1:0]   KLAST = KC_W'(K - 1);
  localparam logic [ADDR_W-1:0] KSTEP = ADDR_W'(K);

  typedef enum logic [1:0] {IDLE, FETCH, DRAIN, DONE} state_t;
  state_t state;

  logic [ADDR_W-1:0] org_ptr, row_ptr, w_step;
  logic [DIM_W-1:0]  xmax, ymax, ox, oy;
  logic [KC_W-1:0]   kx, ky;
  logic              cfg_err;

  // read-return tracking: one read in flight at most per cycle
  logic              rd_vld, rd_wl, rd_fl;

  // 2-entry output FIFO
  logic [DATA_W-1:0] f_data [2];
  logic              f_wl   [2];
  logic              f_fl   [2];
  logic              wr_ptr, rd_ptr;
  logic [1:0]        cnt;

  logic win_end, frm_end, pop, issue, cfg_ok;

  assign cfg_ok    = (cfg_w >= DIM_W'(K)) && (cfg_h >= DIM_W'(K));
  assign win_end   = (kx == KLAST) && (ky == KLAST);
  assign frm_end   = win_end && (ox == xmax) && (oy == ymax);
  assign pix_valid = (cnt != 2'd0);
  assign pop       = pix_valid & pix_ready;
  // The new read's data lands one edge after the in-flight one. Both must fit
  // in the FIFO after this cycle's pop, so a ready consumer sees no bubbles.
  assign issue     = (state == FETCH) &&
                     (({1'b0, cnt} + {2'b0, rd_vld}) < (3'd2 + {2'b0, pop}));
  assign buf_rd_en = issue;

  assign pix_data       = f_data[rd_ptr];
  assign pix_win_last   = f_wl[rd_ptr];
  assign pix_frame_last = f_fl[rd_ptr];

  // sequencer FSM, window/row/origin pointers and status outputs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      busy        <= 1'b0;
      done        <= 1'b0;
      err         <= 1'b0;
      cfg_err     <= 1'b0;
      buf_rd_addr <= '0;
      org_ptr     <= '0;
      row_ptr     <= '0;
      w_step      <= '0;
      xmax        <= '0;
      ymax        <= '0;
      ox          <= '0;
      oy          <= '0;
      kx          <= '0;
      ky          <= '0;
    end else begin
      case (state)
        IDLE: begin
          done <= 1'b0;
          err  <= 1'b0;
          if (start) begin
            busy <= 1'b1;
            if (cfg_ok) begin
              state       <= FETCH;
              cfg_err     <= 1'b0;
              w_step      <= ADDR_W'(cfg_w);
              xmax        <= cfg_w - DIM_W'(K);
              ymax        <= cfg_h - DIM_W'(K);
              buf_rd_addr <= cfg_base;
              org_ptr     <= cfg_base;
              row_ptr     <= cfg_base;
              ox          <= '0;
              oy          <= '0;
              kx          <= '0;
              ky          <= '0;
            end else begin
              state   <= DONE;
              cfg_err <= 1'b1;
            end
          end
        end
        FETCH: begin
          if (issue) begin
            if (frm_end) begin
              // keep the final address on the bus once reads stop
              state <= DRAIN;
            end else if (kx != KLAST) begin
              kx          <= kx + KC_W'(1);
              buf_rd_addr <= buf_rd_addr + ADDR_W'(1);
            end else if (ky != KLAST) begin
              kx          <= '0;
              ky          <= ky + KC_W'(1);
              row_ptr     <= row_ptr + w_step;
              buf_rd_addr <= row_ptr + w_step;
            end else if (ox != xmax) begin
              kx          <= '0;
              ky          <= '0;
              ox          <= ox + DIM_W'(1);
              org_ptr     <= org_ptr + ADDR_W'(1);
              row_ptr     <= org_ptr + ADDR_W'(1);
              buf_rd_addr <= org_ptr + ADDR_W'(1);
            end else begin
              // from origin (oy, W-K) to (oy+1, 0) is exactly +K
              kx          <= '0;
              ky          <= '0;
              ox          <= '0;
              oy          <= oy + DIM_W'(1);
              org_ptr     <= org_ptr + KSTEP;
              row_ptr     <= org_ptr + KSTEP;
              buf_rd_addr <= org_ptr + KSTEP;
            end
          end
        end
        DRAIN: begin
          // finish once the last pixel leaves and nothing else is returning
          if (!rd_vld && ((cnt == 2'd0) || ((cnt == 2'd1) && pop))) begin
            state <= DONE;
            done  <= 1'b1;
            err   <= cfg_err;
          end
        end
        DONE: begin
          if (done) begin
            state <= IDLE;
            done  <= 1'b0;
            err   <= 1'b0;
            busy  <= 1'b0;
          end else begin
            // rejected config: one extra cycle so done lands 2 after start
            done <= 1'b1;
            err  <= cfg_err;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  // read-return pipeline and output FIFO; returning data is always pushed
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_vld <= 1'b0;
      rd_wl  <= 1'b0;
      rd_fl  <= 1'b0;
      wr_ptr <= 1'b0;
      rd_ptr <= 1'b0;
      cnt    <= 2'd0;
      for (int i = 0; i < 2; i++) begin
        f_data[i] <= '0;
        f_wl[i]   <= 1'b0;
        f_fl[i]   <= 1'b0;
      end
    end else begin
      rd_vld <= issue;
      rd_wl  <= issue & win_end;
      rd_fl  <= issue & frm_end;
      if (rd_vld) begin
        f_data[wr_ptr] <= buf_rd_data;
        f_wl[wr_ptr]   <= rd_wl;
        f_fl[wr_ptr]   <= rd_fl;
        wr_ptr         <= ~wr_ptr;
      end
      if (pop) rd_ptr <= ~rd_ptr;
      cnt <= cnt + {1'b0, rd_vld} - {1'b0, pop};
    end
  end

endmodule

// File: tb/tb_window_fetch_ctrl.sv
// Bench for window_fetch_ctrl: buffer memory model and a reference model
// that lists the expected reads and pixels with plain nested loops. A
// per-cycle monitor checks addresses, pixel data, flags, stall stability and
// the amount of outstanding data.
module tb_window_fetch_ctrl;
  localparam int ADDR_W = 13, DATA_W = 16, K = 5, DIM_W = 8, DEPTH = 8192;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic              start = 1'b0;
  logic [ADDR_W-1:0] cfg_base = '0;
  logic [DIM_W-1:0]  cfg_w = '0, cfg_h = '0;
  logic              busy, done, err, buf_rd_en;
  logic [ADDR_W-1:0] buf_rd_addr;
  logic [DATA_W-1:0] buf_rd_data;
  logic [DATA_W-1:0] pix_data;
  logic              pix_valid, pix_win_last, pix_frame_last;
  logic              pix_ready = 1'b1;

  always #5 clk = ~clk;

  window_fetch_ctrl #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .K(K), .DIM_W(DIM_W)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .cfg_base(cfg_base),
    .cfg_w(cfg_w), .cfg_h(cfg_h), .busy(busy), .done(done), .err(err),
    .buf_rd_en(buf_rd_en), .buf_rd_addr(buf_rd_addr), .buf_rd_data(buf_rd_data),
    .pix_data(pix_data), .pix_valid(pix_valid), .pix_ready(pix_ready),
    .pix_win_last(pix_win_last), .pix_frame_last(pix_frame_last)
  );

  // buffer model, 1-cycle read latency
  logic [DATA_W-1:0] mem [DEPTH];
  always @(posedge clk) if (buf_rd_en) buf_rd_data <= mem[buf_rd_addr];

  bit rand_ready = 1'b0;
  always @(posedge clk) begin
    #1;
    pix_ready = rand_ready ? 1'($urandom_range(0, 1)) : 1'b1;
  end

  typedef struct { int addr; bit wl; bit fl; } ref_t;
  ref_t exp_rd[$];
  ref_t exp_px[$];

  int checks = 0, errors = 0;
  bit mon_en = 1'b0;
  int npix, nissued, nacc;
  bit prev_stall;
  logic [DATA_W-1:0] prev_data;
  logic prev_wl, prev_fl;

  function automatic void chk(string nm, longint act, longint exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endfunction

  // per-cycle monitor
  always @(negedge clk) if (mon_en) begin
    ref_t e;
    if (buf_rd_en) begin
      nissued++;
      if (exp_rd.size() == 0) begin
        checks++; errors++;
        $display("FAIL rd_extra: got read at %0d expected none", buf_rd_addr);
      end else begin
        e = exp_rd.pop_front();
        chk("rd_addr", buf_rd_addr, e.addr);
      end
    end
    if (prev_stall) begin
      chk("stall_valid", pix_valid, 1);
      chk("stall_data", pix_data, prev_data);
      chk("stall_wl", pix_win_last, prev_wl);
      chk("stall_fl", pix_frame_last, prev_fl);
    end
    if (pix_valid && pix_ready) begin
      npix++;
      nacc++;
      if (exp_px.size() == 0) begin
        checks++; errors++;
        $display("FAIL pix_extra: got pixel %0d expected none", pix_data);
      end else begin
        e = exp_px.pop_front();
        chk("pix_data", pix_data, mem[e.addr]);
        chk("pix_win_last", pix_win_last, e.wl);
        chk("pix_frame_last", pix_frame_last, e.fl);
      end
    end
    checks++;
    if (nissued - nacc > 2) begin
      errors++;
      $display("FAIL fifo_occ: got %0d outstanding expected <= 2", nissued - nacc);
    end
    prev_stall = pix_valid && !pix_ready;
    prev_data  = pix_data;
    prev_wl    = pix_win_last;
    prev_fl    = pix_frame_last;
  end

  // Runs one frame: builds the expected stream, starts, waits for done.
  // inj > 0 pulses start with a different config at that cycle of the frame.
  task automatic run_frame(input int w, input int h, input int base, input bit rr,
                           input int inj, output int npx, output int dcyc, output bit derr);
    ref_t r;
    exp_rd.delete();
    exp_px.delete();
    if (w >= K && h >= K)
      for (int oy = 0; oy <= h - K; oy++)
        for (int ox = 0; ox <= w - K; ox++)
          for (int ky = 0; ky < K; ky++)
            for (int kx = 0; kx < K; kx++) begin
              r.addr = (base + (oy + ky) * w + ox + kx) % DEPTH;
              r.wl   = (ky == K - 1) && (kx == K - 1);
              r.fl   = r.wl && (oy == h - K) && (ox == w - K);
              exp_rd.push_back(r);
              exp_px.push_back(r);
            end
    npix = 0; nissued = 0; nacc = 0; prev_stall = 1'b0;
    rand_ready = rr;
    mon_en = 1'b1;
    @(negedge clk);
    cfg_base = ADDR_W'(base); cfg_w = DIM_W'(w); cfg_h = DIM_W'(h); start = 1'b1;
    @(posedge clk);
    #2 start = 1'b0;
    dcyc = -1; derr = 1'b0;
    for (int c = 1; c < 6000; c++) begin
      @(negedge clk);
      if (c == 1) chk("busy_c1", busy, 1);
      if (c == inj) begin
        start = 1'b1; cfg_w = 8'd9; cfg_h = 8'd9; cfg_base = 13'd7;
      end else start = 1'b0;
      if (done) begin
        dcyc = c; derr = err;
        break;
      end
    end
    start = 1'b0;
    if (dcyc < 0) begin
      checks++; errors++;
      $display("FAIL done_timeout: got no done expected done within 6000 cycles");
    end
    @(negedge clk);
    chk("done_pulse", done, 0);
    chk("busy_after", busy, 0);
    repeat (3) @(negedge clk);
    mon_en = 1'b0;
    rand_ready = 1'b0;
    chk("rd_left", exp_rd.size(), 0);
    chk("px_left", exp_px.size(), 0);
    npx = npix;
  endtask

  typedef struct { int w; int h; int base; bit rr; int inj; bit e_err; int e_pix; int e_dcyc; } vec_t;

  initial begin
    vec_t vt[8];
    int npx, dcyc, w, h, b, epix;
    bit derr, rr;

    vt[0] = '{5, 5, 0,    0, 0, 0, 25,  28};
    vt[1] = '{6, 5, 100,  0, 0, 0, 50,  53};
    vt[2] = '{5, 5, 8190, 0, 0, 0, 25,  28};
    vt[3] = '{8, 7, 37,   1, 0, 0, 300, -1};
    vt[4] = '{4, 10, 0,   0, 0, 1, 0,   2};
    vt[5] = '{10, 4, 0,   0, 0, 1, 0,   2};
    vt[6] = '{5, 5, 200,  0, 5, 0, 25,  28};
    vt[7] = '{9, 5, 8000, 0, 0, 0, 125, 128};

    for (int i = 0; i < DEPTH; i++) mem[i] = 16'($urandom);

    repeat (3) @(negedge clk);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_rd_en", buf_rd_en, 0);
    chk("rst_rd_addr", buf_rd_addr, 0);
    chk("rst_pix_valid", pix_valid, 0);
    chk("rst_pix_data", pix_data, 0);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    for (int i = 0; i < 8; i++) begin
      run_frame(vt[i].w, vt[i].h, vt[i].base, vt[i].rr, vt[i].inj, npx, dcyc, derr);
      chk("vec_err", derr, vt[i].e_err);
      chk("vec_npix", npx, vt[i].e_pix);
      if (vt[i].e_dcyc >= 0) chk("vec_done_cycle", dcyc, vt[i].e_dcyc);
    end

    // random configurations and backpressure
    for (int i = 0; i < 4; i++) begin
      w = $urandom_range(5, 14);
      h = $urandom_range(5, 9);
      b = $urandom_range(0, DEPTH - 1);
      rr = 1'($urandom_range(0, 1));
      epix = (w - K + 1) * (h - K + 1) * K * K;
      run_frame(w, h, b, rr, 0, npx, dcyc, derr);
      chk("rnd_err", derr, 0);
      chk("rnd_npix", npx, epix);
      if (!rr) chk("rnd_done_cycle", dcyc, epix + 3);
    end

    // asynchronous reset in the middle of FETCH
    @(negedge clk);
    cfg_base = 13'd50; cfg_w = 8'd8; cfg_h = 8'd8; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (10) @(negedge clk);
    chk("pre_rst_busy", busy, 1);
    #2 rst_n = 1'b0;
    #1;
    chk("arst_busy", busy, 0);
    chk("arst_done", done, 0);
    chk("arst_err", err, 0);
    chk("arst_rd_en", buf_rd_en, 0);
    chk("arst_rd_addr", buf_rd_addr, 0);
    chk("arst_pix_valid", pix_valid, 0);
    chk("arst_pix_data", pix_data, 0);
    chk("arst_win_last", pix_win_last, 0);
    chk("arst_frame_last", pix_frame_last, 0);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (3) begin
      @(negedge clk);
      chk("post_rst_done", done, 0);
      chk("post_rst_valid", pix_valid, 0);
    end
    run_frame(5, 5, 0, 0, 0, npx, dcyc, derr);
    chk("post_rst_npix", npx, 25);
    chk("post_rst_done_cycle", dcyc, 28);
    chk("post_rst_err", derr, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/window_fetch_ctrl.md
# window_fetch_ctrl

Read-side sequencer for the 16-bit, 8192-deep feature-map buffer. It walks a KxK stride-1 window across a W x H image stored row-major in the buffer and issues one read address per cycle. It absorbs the buffer's 1-cycle read latency and streams the window pixels, with valid/ready flow control, to the convolution engine. Sits between the buffer's read port and the conv kernel input.

## Interface
Parameters:
- ADDR_W, 13, buffer address width
- DATA_W, 16, pixel width
- K, 5, window size (square, stride 1)
- DIM_W, 8, width of cfg_w / cfg_h

Ports:
- clk  in  1  sole clock, rising edge
- rst_n  in  1  asynchronous active-low reset
- start  in  1  begin a frame; sampled only in IDLE
- cfg_base  in  ADDR_W  buffer address of pixel (0,0); latched on start
- cfg_w  in  DIM_W  image width; latched on start
- cfg_h  in  DIM_W  image height; latched on start
- busy  out  1  high from the cycle after an accepted start until the done cycle, inclusive
- done  out  1  1-cycle pulse at frame end
- err  out  1  valid with done; 1 = config rejected
- buf_rd_en  out  1  read issued this cycle
- buf_rd_addr  out  ADDR_W  read address; buffer returns data the next cycle
- buf_rd_data  in  DATA_W  buffer read data (1-cycle latency)
- pix_data  out  DATA_W  window pixel
- pix_valid  out  1  pix_data valid
- pix_ready  in  1  consumer accepts when valid & ready
- pix_win_last  out  1  last pixel of the current window
- pix_frame_last  out  1  last pixel of the frame

## Operation
- States: IDLE, FETCH, DRAIN, DONE.
- IDLE -> FETCH on start when cfg_w >= K and cfg_h >= K. IDLE -> DONE with err=1 otherwise; no reads are issued in that case.
- FETCH: issue reads for every window position (oy, ox), with oy in 0..H-K and ox in 0..W-K, outer loop oy, inner loop ox. Within each window, reads run in row-major order: ky outer, kx inner.
- Address = cfg_base + (oy+ky)*W + (ox+kx), truncated to ADDR_W. Wraps modulo 2^ADDR_W.
- Addresses are generated incrementally with adders: a window-origin pointer and a row pointer. No multiplier is used.
- After the last read is issued, FETCH -> DRAIN.
- DRAIN -> DONE when the output FIFO is empty and no read is in flight.
- DONE: done=1 for one cycle, err as decided, then -> IDLE.
- Output buffering: a 2-entry FIFO. Returning read data is pushed into it unconditionally.
- Issue rule: a read issues only when occupancy + inflight - pop_this_cycle < 2. This guarantees no overflow and sustains 1 pixel/cycle while pix_ready is held high.
- pix_win_last and pix_frame_last are carried with each read through the pipeline and FIFO. They are aligned with their pixel.
- Pixels per frame = (W-K+1)*(H-K+1)*K*K.
- start while busy is ignored. cfg_* changes while busy have no effect.
- Reset, asynchronous at any time including mid-frame:
  - state returns to IDLE
  - FIFO and inflight are cleared
  - busy, done, err, buf_rd_en and pix_valid = 0
  - buf_rd_addr, pix_data and the last flags = 0
  - no pixel or done is produced for the aborted frame

## Timing
- start sampled high at edge 0 (IDLE, valid config):
  - cycle 1: busy=1, buf_rd_en=1, buf_rd_addr=cfg_base
  - cycle 2: buf_rd_data valid
  - cycle 3: pix_valid=1 with the first pixel
- With pix_ready held high: one read per cycle, one pixel per cycle, no bubbles across window or row boundaries.
- When buf_rd_en=0, buf_rd_addr holds its previous value.
- When pix_valid=1 and pix_ready=0, pix_data and the flags hold stable.
- done asserts the cycle after the final pixel handshake, or 2 cycles after start for err.
- In the done cycle busy=1; busy=0 the cycle after.
- A new start is accepted in the cycle after done.

## Test plan
- W=5, H=5, base=0, ready=1: addresses 0..24 in order. 25 pixels, each equal to the buffer contents at that address. win_last and frame_last set only on pixel 25. done pulses at cycle 28.
- W=6, H=5, base=100: 50 pixels. Window 0 rows start at 100/106/112/118/124. Window 1 starts at 101. win_last on pixels 25 and 50. frame_last only on pixel 50.
- base=8190, W=5, H=5: addresses 8190, 8191, 0, 1, 2, ... wrap correctly. Data matches.
- Random pix_ready (50%), W=8, H=7: every pixel delivered exactly once, in order, no drops or duplicates. FIFO never exceeds 2. Data and flags stable while stalled.
- cfg_w=4, H=10: no buf_rd_en. done=1 with err=1 two cycles after start. start pulsed while busy on a valid frame: ignored.
- rst_n low mid-FETCH: outputs zero immediately. After release, a new start (W=5, H=5) produces exactly 25 clean pixels.
